ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 12, byte-address bits decoded; memory size is 2**ADDR_WIDTH bytes.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, bus width; legal values are 32 or 64.
REQ-003 SHALL provide parameter WAIT_STATES, default 0, data-phase wait cycles per transfer; legal range 0..7.
REQ-004 SHALL have port hclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port hresetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port hsel, input, 1 bit: slave select.
REQ-007 SHALL have port haddr, input, 32 bits: byte address.
REQ-008 SHALL have port htrans, input, 2 bits: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-009 SHALL have port hwrite, input, 1 bit: 1 = write.
REQ-010 SHALL have port hsize, input, 3 bits: transfer size, 2**hsize bytes.
REQ-011 SHALL have port hburst, input, 3 bits: accepted; no functional effect.
REQ-012 SHALL have port hprot, input, 4 bits: protection; bit1 = privileged.
REQ-013 SHALL have port hwdata, input, DATA_WIDTH bits: write data.
REQ-014 SHALL have port hready, input, 1 bit: bus ready, previous transfer completing.
REQ-015 SHALL have port hreadyout, output, 1 bit: slave ready.
REQ-016 SHALL have port hresp, output, 2 bits: OKAY=0, ERROR=1.
REQ-017 SHALL have port hrdata, output, DATA_WIDTH bits: read data.

Function
REQ-018 SHALL accept a transfer only when hsel=1, htrans[1]=1 and hready=1; the address phase is captured in that cycle (address, size, write, prot).
REQ-019 SHALL use FSM states IDLE, WAIT, ERR1, ERR2.
- IDLE: accept. Valid transfer with WAIT_STATES>0 -> WAIT; with WAIT_STATES=0, complete in the next cycle and stay in IDLE. Erroneous transfer -> ERR1.
- WAIT: down-counter runs; hreadyout=0 for exactly WAIT_STATES cycles, then hreadyout=1 for the completing cycle -> IDLE, or accept a pipelined transfer.
- ERR1: hreadyout=0, hresp=ERROR -> ERR2.
- ERR2: hreadyout=1, hresp=ERROR -> IDLE.
REQ-020 SHALL flag a transfer as erroneous if any of these hold:
- haddr[31:ADDR_WIDTH] is non-zero;
- 2**hsize exceeds DATA_WIDTH/8;
- haddr is not aligned to 2**hsize.
An erroneous transfer SHALL NOT access memory.
REQ-021 SHALL derive byte enables from the captured hsize and the low address bits; only the addressed lanes are written.
REQ-022 SHALL write hwdata to memory on the completing (hreadyout=1) cycle of a write data phase.
REQ-023 SHALL drive hrdata with the full addressed word during the completing cycle of a read; a read immediately after a write to the same word returns the new data.
REQ-024 SHALL respond to IDLE/BUSY transfers, or unselected cycles, with zero-wait OKAY and no memory access.
REQ-025 SHALL keep hrdata at 0 outside read completing cycles.

Reset
REQ-026 SHALL, with hresetn=0 at a rising hclk, force: FSM=IDLE, wait counter=0, hreadyout=1, hresp=OKAY, hrdata=0.
REQ-027 SHALL abandon any transfer in progress when reset is asserted mid-transfer, with no memory write.
REQ-028 SHALL NOT reset memory contents.

Configuration
REQ-029 With AHB_SRAM_SLAVE_PROT_EN defined, SHALL treat any write with hprot[1]=0 to the upper half of memory (haddr[ADDR_WIDTH-1]=1) as erroneous (two-cycle ERROR, no write).
REQ-030 Without AHB_SRAM_SLAVE_PROT_EN, SHALL ignore hprot entirely.

Verification
REQ-031 Write word 0xDEADBEEF to 0x010, then read 0x010 (WAIT_STATES=0) -> both complete with no wait, OKAY; hrdata=0xDEADBEEF.
REQ-032 WAIT_STATES=3, read 0x020 -> hreadyout low for 3 cycles, high on the 4th with data, hresp=OKAY.
REQ-033 Byte write 0xAA to 0x013 over 0x11223344 -> word reads back 0xAA223344 (little-endian, lanes [31:24]).
REQ-034 Access 0x1000 with ADDR_WIDTH=12, or halfword at 0x001 -> hresp=ERROR with hreadyout 0 then 1; memory unchanged.
REQ-035 With AHB_SRAM_SLAVE_PROT_EN, hprot=0x0 write to 0x800 -> ERROR; same write with hprot=0x2 -> OKAY.
REQ-036 hresetn=0 during a WAIT state -> next cycle hreadyout=1, hresp=OKAY, hrdata=0; target word not written.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with optional wait states and error responses; optional AHB_SRAM_SLAVE_PROT_EN
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic [1:0]            hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(NBYTES);
    localparam int DEPTH     = 2 ** (ADDR_WIDTH - LANE_BITS);

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    state_t                  state, next_state;
    logic [2:0]              wait_cnt;
    logic                    slave_ready;
    logic                    err_resp;
    logic                    accept;
    logic                    xfer_err;
    logic                    complete;
    logic [LANE_BITS-1:0]    align_mask;
    logic [LANE_BITS-1:0]    lane_ones;
    logic [NBYTES-1:0]       byte_en;

    logic                    dp_valid;
    logic                    dp_write;
    logic [ADDR_WIDTH-1:0]   dp_addr;
    logic [2:0]              dp_size;
    logic [ADDR_WIDTH-LANE_BITS-1:0] word_idx;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    // Burst type never changes behaviour; protection is only consulted when the write guard is built in.
    logic unused_inputs;
    assign unused_inputs = ^{hburst, hprot};

    // Classify the transfer presented in the address phase as erroneous or not.
    always_comb begin
        lane_ones  = '1;
        align_mask = ~(lane_ones << hsize);
        xfer_err   = 1'b0;
        if (|haddr[31:ADDR_WIDTH])
            xfer_err = 1'b1;
        if (hsize > 3'(LANE_BITS))
            xfer_err = 1'b1;
        if (|(haddr[LANE_BITS-1:0] & align_mask))
            xfer_err = 1'b1;
`ifdef AHB_SRAM_SLAVE_PROT_EN
        if (hwrite && !hprot[1] && haddr[ADDR_WIDTH-1])
            xfer_err = 1'b1;
`endif
    end

    // State register.
    always_ff @(posedge hclk) begin
        if (!hresetn)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next state and response outputs; ERR2 is a ready cycle, so a pipelined transfer may be accepted there.
    always_comb begin
        next_state  = state;
        slave_ready = 1'b1;
        err_resp    = 1'b0;
        case (state)
            IDLE: slave_ready = 1'b1;
            WAIT: slave_ready = (wait_cnt == 3'd0);
            ERR1: begin
                slave_ready = 1'b0;
                err_resp    = 1'b1;
            end
            ERR2: err_resp = 1'b1;
            default: slave_ready = 1'b1;
        endcase
        accept = hsel && htrans[1] && hready && slave_ready;
        if (slave_ready) begin
            if (accept && xfer_err)
                next_state = ERR1;
            else if (accept && (WAIT_STATES > 0))
                next_state = WAIT;
            else
                next_state = IDLE;
        end else if (state == ERR1) begin
            next_state = ERR2;
        end
    end

    assign hreadyout = slave_ready;
    assign hresp     = {1'b0, err_resp};

    // Wait-state down-counter, loaded when a good transfer is accepted.
    always_ff @(posedge hclk) begin
        if (!hresetn)
            wait_cnt <= 3'd0;
        else if (accept && !xfer_err && (WAIT_STATES > 0))
            wait_cnt <= 3'(WAIT_STATES);
        else if (wait_cnt != 3'd0)
            wait_cnt <= wait_cnt - 3'd1;
    end

    // Address-phase capture; held while the current data phase is stalled.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= 3'd0;
        end else if (slave_ready) begin
            dp_valid <= accept && !xfer_err;
            dp_write <= hwrite;
            dp_addr  <= haddr[ADDR_WIDTH-1:0];
            dp_size  <= hsize;
        end
    end

    assign complete = dp_valid && slave_ready;
    assign word_idx = dp_addr[ADDR_WIDTH-1:LANE_BITS];

    // A lane is enabled when it falls in the same naturally aligned 2**size block as the address.
    always_comb begin
        byte_en = '0;
        for (int i = 0; i < NBYTES; i++)
            byte_en[i] = ((LANE_BITS'(i) >> dp_size) == (dp_addr[LANE_BITS-1:0] >> dp_size));
    end

    // Memory write on the completing cycle; a reset in that cycle suppresses it. Contents are never cleared.
    always_ff @(posedge hclk) begin
        if (hresetn && complete && dp_write) begin
            for (int i = 0; i < NBYTES; i++)
                if (byte_en[i])
                    mem[word_idx][8*i +: 8] <= hwdata[8*i +: 8];
        end
    end

    assign hrdata = (complete && !dp_write) ? mem[word_idx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed self-checking bench for ahb_sram_slave (zero-wait and three-wait instances)
module tb_ahb_sram_slave;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;

    logic        hsel0, hreadyout0;
    logic [1:0]  hresp0;
    logic [31:0] hrdata0;
    logic        hsel3, hreadyout3;
    logic [1:0]  hresp3;
    logic [31:0] hrdata3;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd;
    logic [1:0]  fr, rs;
    int          nw;
    logic [1:0]  exp_prot_resp;
    int          exp_prot_waits;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(0)) u0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hreadyout0), .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_STATES(3)) u3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hreadyout3), .hreadyout(hreadyout3), .hresp(hresp3), .hrdata(hrdata3)
    );

    function automatic logic cur_ready(input int which);
        return (which == 3) ? hreadyout3 : hreadyout0;
    endfunction

    function automatic logic [1:0] cur_resp(input int which);
        return (which == 3) ? hresp3 : hresp0;
    endfunction

    function automatic logic [31:0] cur_rdata(input int which);
        return (which == 3) ? hrdata3 : hrdata0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single non-pipelined transfer; entered and left #1 after a rising edge.
    task automatic xfer(input int which, input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [3:0] prot, input logic [31:0] wd,
                        output logic [31:0] rdo, output logic [1:0] first_resp,
                        output logic [1:0] resp, output int waits);
        hsel0  = (which == 0);
        hsel3  = (which == 3);
        haddr  = addr;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = size;
        hprot  = prot;
        @(posedge hclk); #1;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hwdata = wd;
        waits  = 0;
        first_resp = cur_resp(which);
        while (!cur_ready(which) && waits < 20) begin
            @(posedge hclk); #1;
            waits++;
        end
        rdo  = cur_rdata(which);
        resp = cur_resp(which);
        @(posedge hclk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef AHB_SRAM_SLAVE_PROT_EN
        exp_prot_resp  = 2'd1;
        exp_prot_waits = 1;
`else
        exp_prot_resp  = 2'd0;
        exp_prot_waits = 0;
`endif
        hresetn = 1'b0;
        hsel0 = 1'b0; hsel3 = 1'b0;
        haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
        hburst = 3'd0; hprot = 4'h3; hwdata = 32'h0;

        // Reset state
        repeat (3) @(posedge hclk);
        #1;
        check("rst_ready0", {31'h0, hreadyout0}, 32'h1);
        check("rst_resp0",  {30'h0, hresp0},     32'h0);
        check("rst_rdata0", hrdata0,             32'h0);
        check("rst_ready3", {31'h0, hreadyout3}, 32'h1);
        check("rst_resp3",  {30'h0, hresp3},     32'h0);
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // Word write then read, zero wait
        xfer(0, 1'b1, 32'h010, 3'd2, 4'h3, 32'hDEADBEEF, rd, fr, rs, nw);
        check("wr010_waits", nw, 0);
        check("wr010_resp",  {30'h0, rs}, 32'h0);
        xfer(0, 1'b0, 32'h010, 3'd2, 4'h3, 32'h0, rd, fr, rs, nw);
        check("rd010_waits", nw, 0);
        check("rd010_resp",  {30'h0, rs}, 32'h0);
        check("rd010_data",  rd, 32'hDEADBEEF);
        check("idle_rdata0", hrdata0, 32'h0);

        // Byte and halfword lane writes
        xfer(0, 1'b1, 32'h010, 3'd2, 4'h3, 32'h11223344, rd, fr, rs, nw);
        xfer(0, 1'b1, 32'h013, 3'd0, 4'h3, 32'hAA000000, rd, fr, rs, nw);
        check("wrb013_resp", {30'h0, rs}, 32'h0);
        xfer(0, 1'b0, 32'h010, 3'd2, 4'h3, 32'h0, rd, fr, rs, nw);
        check("rd_byte_lane", rd, 32'hAA223344);
        xfer(0, 1'b1, 32'h010, 3'd1, 4'h3, 32'hFFFFBEEF, rd, fr, rs, nw);
        xfer(0, 1'b0, 32'h010, 3'd2, 4'h3, 32'h0, rd, fr, rs, nw);
        check("rd_half_lane", rd, 32'hAA22BEEF);

        // Error responses leave memory untouched
        xfer(0, 1'b1, 32'h000, 3'd2, 4'h3, 32'h5A5A5A5A, rd, fr, rs, nw);
        xfer(0, 1'b1, 32'h1000, 3'd2, 4'h3, 32'hFFFFFFFF, rd, fr, rs, nw);
        check("oob_first_resp", {30'h0, fr}, 32'h1);
        check("oob_waits",      nw, 1);
        check("oob_resp",       {30'h0, rs}, 32'h1);
        xfer(0, 1'b1, 32'h001, 3'd1, 4'h3, 32'hFFFFFFFF, rd, fr, rs, nw);
        check("misalign_resp",  {30'h0, rs}, 32'h1);
        check("misalign_waits", nw, 1);
        xfer(0, 1'b1, 32'h000, 3'd3, 4'h3, 32'hFFFFFFFF, rd, fr, rs, nw);
        check("oversize_resp",  {30'h0, rs}, 32'h1);
        xfer(0, 1'b0, 32'h000, 3'd2, 4'h3, 32'h0, rd, fr, rs, nw);
        check("err_mem_kept",   rd, 32'h5A5A5A5A);
        check("err_after_resp", {30'h0, rs}, 32'h0);

        // Pipelined write then read of the same word
        hsel0 = 1'b1; haddr = 32'h040; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk); #1;
        hwdata = 32'hCAFEF00D; hwrite = 1'b0;
        check("pipe_wr_ready", {31'h0, hreadyout0}, 32'h1);
        @(posedge hclk); #1;
        hsel0 = 1'b0; htrans = 2'b00;
        check("pipe_rd_data",  hrdata0, 32'hCAFEF00D);
        check("pipe_rd_ready", {31'h0, hreadyout0}, 32'h1);
        @(posedge hclk); #1;

        // BUSY transfer: OKAY, no access
        hsel0 = 1'b1; haddr = 32'h040; htrans = 2'b01; hwrite = 1'b1;
        @(posedge hclk); #1;
        hsel0 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0;
        check("busy_ready", {31'h0, hreadyout0}, 32'h1);
        check("busy_resp",  {30'h0, hresp0}, 32'h0);
        @(posedge hclk); #1;
        xfer(0, 1'b0, 32'h040, 3'd2, 4'h3, 32'h0, rd, fr, rs, nw);
        check("busy_no_write", rd, 32'hCAFEF00D);

        // Protection guard on upper half
        xfer(0, 1'b1, 32'h800, 3'd2, 4'h0, 32'h0BADF00D, rd, fr, rs, nw);
        check("prot0_resp",  {30'h0, rs}, {30'h0, exp_prot_resp});
        check("prot0_waits", nw, exp_prot_waits);
        xfer(0, 1'b1, 32'h800, 3'd2, 4'h2, 32'h0BADF00D, rd, fr, rs, nw);
        check("prot2_resp",  {30'h0, rs}, 32'h0);
        xfer(0, 1'b0, 32'h800, 3'd2, 4'h0, 32'h0, rd, fr, rs, nw);
        check("prot_rd_data", rd, 32'h0BADF00D);

        // Three wait states
        xfer(3, 1'b1, 32'h020, 3'd2, 4'h3, 32'h12345678, rd, fr, rs, nw);
        check("ws3_wr_waits", nw, 3);
        xfer(3, 1'b0, 32'h020, 3'd2, 4'h3, 32'h0, rd, fr, rs, nw);
        check("ws3_rd_waits", nw, 3);
        check("ws3_rd_resp",  {30'h0, rs}, 32'h0);
        check("ws3_rd_data",  rd, 32'h12345678);

        // Reset during a wait state abandons the write
        xfer(3, 1'b1, 32'h030, 3'd2, 4'h3, 32'h11111111, rd, fr, rs, nw);
        hsel3 = 1'b1; haddr = 32'h030; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel3 = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h22222222;
        check("ws3_stall", {31'h0, hreadyout3}, 32'h0);
        hresetn = 1'b0;
        @(posedge hclk); #1;
        check("mid_rst_ready", {31'h0, hreadyout3}, 32'h1);
        check("mid_rst_resp",  {30'h0, hresp3}, 32'h0);
        check("mid_rst_rdata", hrdata3, 32'h0);
        hresetn = 1'b1;
        repeat (5) @(posedge hclk);
        #1;
        xfer(3, 1'b0, 32'h030, 3'd2, 4'h3, 32'h0, rd, fr, rs, nw);
        check("mid_rst_no_write", rd, 32'h11111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
